// File: rtl/fetch_exc_unit_if.sv
// fetch_exc_unit_if: instruction-memory bus between the fetch stage and imem
interface fetch_exc_unit_if #(parameter int N = 64);
  logic [N-1:0] imem_addr;
  logic [31:0]  imem_data;
  logic         imem_ready;
  modport master (output imem_addr, input imem_data, imem_ready);
  modport slave  (input imem_addr, output imem_data, imem_ready);
endinterface

// File: rtl/fetch_exc_unit.sv
// fetch_exc_unit: PC, next-PC selection and exception entry/return sequencing
module fetch_exc_unit #(
  parameter int           N          = 64,
  parameter logic [N-1:0] RESET_PC   = 64'h0,
  parameter logic [N-1:0] EXC_VECTOR = 64'hD8,
  parameter logic [3:0]   IRQ_CAUSE  = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_exc_unit_if.master     bus,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [N-1:0]         PC,
  input  logic [N-1:0]         PCBranch,
  input  logic                 PCSrc,
  input  logic                 Exc,
  input  logic [3:0]           ExcCause,
  input  logic                 IRQ,
  input  logic                 ERet,
  output logic [N-1:0]         ELR,
  output logic [3:0]           ESR,
  output logic                 EMode,
  output logic                 Halted
);
  typedef enum logic [1:0] {NORMAL = 2'b00, HANDLER = 2'b01, HALT = 2'b10} state_t;
  state_t       state, state_n;
  logic [N-1:0] pc, pc_n, elr, elr_n, nxt;
  logic [3:0]   esr, esr_n;
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc    <= RESET_PC;
      elr   <= '0;
      esr   <= '0;
      state <= NORMAL;
    end else begin
      pc    <= pc_n;
      elr   <= elr_n;
      esr   <= esr_n;
      state <= state_n;
    end
  end
  assign instr_valid   = bus.imem_ready && state != HALT;
  assign instr         = instr_valid ? bus.imem_data : 32'h0;
  assign bus.imem_addr = pc;
  assign PC            = pc;
  assign ELR           = elr;
  assign ESR           = esr;
  assign EMode         = state == HANDLER;
  assign Halted        = state == HALT;
  assign nxt           = PCSrc ? PCBranch : pc + N'(4);
  // IRQ entry lets the current instruction finish, so it links to nxt; Exc links to the faulting PC
  always_comb begin
    pc_n    = pc;
    elr_n   = elr;
    esr_n   = esr;
    state_n = state;
    if (instr_valid && state == NORMAL) begin
      if (Exc || IRQ) begin
        elr_n   = Exc ? pc : nxt;
        esr_n   = Exc ? ExcCause : IRQ_CAUSE;
        pc_n    = EXC_VECTOR;
        state_n = HANDLER;
      end else
        pc_n = nxt;
    end else if (instr_valid && state == HANDLER) begin
      if (Exc)
        state_n = HALT;
      else if (ERet) begin
        pc_n    = elr;
        state_n = NORMAL;
      end else
        pc_n = nxt;
    end
  end
endmodule

// File: tb/tb_fetch_exc_unit.sv
// tb_fetch_exc_unit: scoreboard bench; driver pushes expected next state, monitor pops after each edge
module tb_fetch_exc_unit;
  logic        clk = 0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [63:0] PC, PCBranch, ELR;
  logic        PCSrc, Exc, IRQ, ERet, EMode, Halted;
  logic [3:0]  ExcCause, ESR;
  int          errors = 0, checks = 0;
  typedef struct {logic [63:0] pc, elr; logic [3:0] esr; logic [1:0] st;} exp_t;
  exp_t        q[$];
  logic [63:0] m_pc = 0, m_elr = 0;
  logic [3:0]  m_esr = 0;
  logic [1:0]  m_st = 0;
  bit          known = 0;
  fetch_exc_unit_if #(.N(64)) bus ();
  fetch_exc_unit dut (
    .clk(clk), .reset(reset), .bus(bus), .instr(instr), .instr_valid(instr_valid),
    .PC(PC), .PCBranch(PCBranch), .PCSrc(PCSrc), .Exc(Exc), .ExcCause(ExcCause),
    .IRQ(IRQ), .ERet(ERet), .ELR(ELR), .ESR(ESR), .EMode(EMode), .Halted(Halted)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pc", PC, e.pc);
      check("imem_addr", bus.imem_addr, e.pc);
      check("elr", ELR, e.elr);
      check("esr", {60'h0, ESR}, {60'h0, e.esr});
      check("emode", {63'h0, EMode}, {63'h0, e.st == 2'd1});
      check("halted", {63'h0, Halted}, {63'h0, e.st == 2'd2});
    end
  end
  task automatic drive(input logic rdy, ps, input logic [63:0] br, input logic ex,
                       input logic [3:0] cs, input logic irq_i, er, rn);
    logic        valid;
    logic [63:0] nxt;
    logic [31:0] data;
    data = m_pc[31:0] ^ 32'h8B1F_0000;
    bus.imem_ready = rdy; bus.imem_data = data;
    PCSrc = ps; PCBranch = br; Exc = ex; ExcCause = cs; IRQ = irq_i; ERet = er; reset = rn;
    #1;
    valid = rdy && m_st != 2'd2;
    if (known) begin
      check("instr_valid", {63'h0, instr_valid}, {63'h0, valid});
      check("instr", {32'h0, instr}, {32'h0, valid ? data : 32'h0});
    end
    nxt = ps ? br : m_pc + 64'd4;
    if (!rn) begin
      m_pc = 0; m_elr = 0; m_esr = 0; m_st = 0; known = 1;
    end else if (valid && m_st == 2'd0) begin
      if (ex) begin m_elr = m_pc; m_esr = cs; m_pc = 64'hD8; m_st = 1; end
      else if (irq_i) begin m_elr = nxt; m_esr = 4'hF; m_pc = 64'hD8; m_st = 1; end
      else m_pc = nxt;
    end else if (valid && m_st == 2'd1) begin
      if (ex) m_st = 2;
      else if (er) begin m_pc = m_elr; m_st = 0; end
      else m_pc = nxt;
    end
    q.push_back('{m_pc, m_elr, m_esr, m_st});
    @(negedge clk);
  endtask
  task automatic idle();            drive(1, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic jump(input logic [63:0] a); drive(1, 1, a, 0, 0, 0, 0, 1); endtask
  task automatic rst();             drive(1, 1, 64'h55, 1, 4'h7, 1, 1, 0); endtask
  initial begin
    bus.imem_ready = 0; bus.imem_data = 0; reset = 0;
    PCSrc = 0; PCBranch = 0; Exc = 0; ExcCause = 0; IRQ = 0; ERet = 0;
    @(negedge clk);
    rst(); rst();
    check("rst_pc", PC, 64'h0);
    repeat (3) idle();
    check("tp1_pc", PC, 64'hC);
    idle();
    jump(64'h40);
    check("tp2_br", PC, 64'h40);
    drive(0, 1, 64'h99, 1, 4'h2, 1, 1, 1);
    drive(0, 1, 64'h99, 1, 4'h2, 1, 1, 1);
    check("tp2_hold", PC, 64'h40);
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    check("eret_normal", PC, 64'h44);
    jump(64'h20);
    drive(1, 0, 0, 1, 4'h1, 0, 0, 1);
    check("tp3_elr", ELR, 64'h20);
    check("tp3_vec", PC, 64'hD8);
    idle();
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    check("tp3_ret", PC, 64'h20);
    jump(64'h30);
    drive(1, 1, 64'h80, 0, 0, 1, 0, 1);
    check("tp4_elr", ELR, 64'h80);
    check("tp4_esr", {60'h0, ESR}, 64'hF);
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    check("tp4_mask", PC, 64'hDC);
    drive(1, 0, 0, 0, 0, 1, 1, 1);
    check("tp4_ret", PC, 64'h80);
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    check("tp4_reirq", ELR, 64'h84);
    drive(1, 0, 0, 1, 4'h3, 0, 0, 1);
    check("tp5_halt", {63'h0, Halted}, 64'h1);
    repeat (5) drive(1, 1, 64'h300, 1, 4'h5, 1, 1, 1);
    check("tp5_frozen", PC, 64'hD8);
    rst();
    check("tp5_rst_elr", ELR, 64'h0);
    jump(64'hFFFF_FFFF_FFFF_FFFC);
    idle();
    check("tp6_wrap", PC, 64'h0);
    drive(1, 0, 0, 1, 4'h3, 0, 0, 1);
    drive(1, 0, 0, 1, 4'h6, 0, 1, 1);
    check("tp6_exc_wins", {63'h0, Halted}, 64'h1);
    rst();
    drive(1, 0, 0, 1, 4'h2, 0, 0, 1);
    idle();
    rst();
    check("rst_mid_handler", {63'h0, EMode}, 64'h0);
    for (int i = 0; i < 120; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            {$urandom, $urandom} & ~64'h3, $urandom_range(0, 7) == 0,
            4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 24) != 0);
    check("drain", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_exc_unit.md
Name: fetch_exc_unit

Overview:
- Instruction-fetch and exception-sequencing stage directly upstream of the main decoder in the single-cycle LEGv8 core with exceptions.
- Owns the PC register and drives the instruction word whose bits [31:21] form the decoder Op field.
- Selects next PC from sequential, branch, exception-vector and exception-return sources.
- Holds the exception link (ELR) and syndrome (ESR) registers, and tracks a NORMAL/HANDLER/HALT mode FSM.

Parameters:
N, 64, PC/address width
RESET_PC, 64'h0, PC value loaded on reset
EXC_VECTOR, 64'hD8, handler entry address
IRQ_CAUSE, 4'hF, ESR code written on interrupt entry

Ports:
clk  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
imem_addr  out  N  instruction memory address (= current PC)
imem_data  in  32  instruction word at imem_addr (combinational memory)
imem_ready  in  1  imem_data valid this cycle
instr  out  32  instruction to decoder; 32'h0 when instr_valid=0
instr_valid  out  1  instruction commits this cycle
PC  out  N  current PC, for branch adder
PCBranch  in  N  branch target
PCSrc  in  1  branch taken (decoder Branch AND zero)
Exc  in  1  synchronous exception for current instruction (e.g. invalid opcode)
ExcCause  in  4  cause code accompanying Exc
IRQ  in  1  level-sensitive external interrupt request
ERet  in  1  current instruction is exception return
ELR  out  N  exception link register
ESR  out  4  exception syndrome register
EMode  out  1  1 while in HANDLER
Halted  out  1  1 in HALT

Behaviour:
- Reset (reset=0 at edge): PC=RESET_PC, ELR=0, ESR=0, state=NORMAL. EMode=0, Halted=0.
- instr_valid = imem_ready AND state!=HALT.
- instr = instr_valid ? imem_data : 32'h0. An all-zero word decodes to all-zero controls, so no writes occur.
- instr_valid=0 cycle: PC, ELR, ESR and state hold. PCSrc, Exc, ERet and IRQ are ignored. IRQ stays pending as a level.
- seq = PC+4, modulo 2^N (wraps silently). nxt = PCSrc ? PCBranch : seq.
- States: NORMAL(00), HANDLER(01), HALT(10). EMode = (state==HANDLER). Halted = (state==HALT).
- NORMAL, valid cycle, priority Exc > IRQ > ERet/none:
  - Exc: ELR<=PC, ESR<=ExcCause, PC<=EXC_VECTOR, go HANDLER.
  - IRQ: the instruction completes. ELR<=nxt, ESR<=IRQ_CAUSE, PC<=EXC_VECTOR, go HANDLER.
  - Otherwise PC<=nxt. ERet in NORMAL has no special effect: PC<=nxt.
- HANDLER, valid cycle, priority Exc > ERet > none:
  - Exc (double fault): go HALT. PC, ELR and ESR hold.
  - ERet: PC<=ELR, go NORMAL. ELR and ESR hold.
  - Otherwise PC<=nxt.
  - IRQ is masked in HANDLER and is taken on the first valid NORMAL cycle after return, if still asserted.
- HALT: PC, ELR and ESR frozen; instr_valid=0; only reset exits.
- Exc, PCSrc and ERet are combinational functions of instr in the same cycle. This block registers only; it has no combinational path from those inputs to instr.
- Reset mid-handler or in HALT: full reset values next cycle regardless of other inputs.
- Latency: a redirect (branch, vector, return) appears on imem_addr the cycle after the commit cycle. There are no bubbles.

Test Plan:
1. Reset, then imem_ready=1 with no events for 3 cycles -> PC 0, 4, 8, 0xC. instr equals imem_data; EMode=0.
2. At PC=0x10: PCSrc=1, PCBranch=0x40 -> next PC=0x40. Then hold imem_ready=0 for 2 cycles -> PC stays 0x40, instr=0, instr_valid=0.
3. At PC=0x20: Exc=1, ExcCause=4'h1 -> ELR=0x20, ESR=1, PC=0xD8, EMode=1. Handler at 0xDC issues ERet -> PC=0x20, EMode=0.
4. At PC=0x30: IRQ=1 with PCSrc=1, PCBranch=0x80 -> ELR=0x80, ESR=0xF, PC=0xD8. IRQ held high in HANDLER -> not re-taken. ERet -> PC=0x80, then IRQ taken again on that cycle.
5. In HANDLER: Exc=1 -> Halted=1, instr_valid=0, PC frozen for 5 cycles. reset=0 for 1 cycle -> PC=0, Halted=0, ELR=0, ESR=0.
6. Set PC to 2^N-4 via PCBranch -> next sequential PC=0. Exc and ERet together in HANDLER -> HALT (Exc wins).
